// File: rtl/serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// serial_adder_ctrl -- bit-serial WIDTH-bit adder built on one 1-bit full_adder.
//
// Two WIDTH-bit operands are captured on an accepted start. One bit pair is
// fed through the full adder per clock, LSB first. The carry is kept in a
// flop between bit slices, and the sum is assembled MSB-first in a shift
// register. A one-cycle done pulse marks sum_out/cout as valid.
//
// Handshake: start is a request that is accepted only when busy==0, that is
// in IDLE or in the DONE cycle. An accepted start shows up as busy=1 on the
// next cycle. Requests made while busy==1 are dropped. done pulses for
// exactly one cycle. sum_out/cout are then held until the next accepted start.
//
// Ports:
//   clock     in   1      rising-edge clock
//   resetn    in   1      asynchronous active-low reset
//   start     in   1      request a new addition (sampled only when busy==0)
//   a_in      in   WIDTH  operand A, captured on an accepted start
//   b_in      in   WIDTH  operand B, captured on an accepted start
//   cin       in   1      carry-in, captured on an accepted start
//   sub       in   1      (SERIAL_ADDER_SUB_EN only) 1 = compute a_in - b_in
//   busy      out  1      high while a serial addition is running
//   done      out  1      one-cycle pulse when sum_out/cout become valid
//   sum_out   out  WIDTH  result
//   cout      out  1      final carry-out (no-borrow flag when subtracting)
//   fsm_state out  2      debug view of the controller state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature macro: SERIAL_ADDER_SUB_EN adds the sub port and
// two's-complement subtraction.
//
// Timing: start accepted at edge 0 -> busy during cycles 1..WIDTH -> done
// during cycle WIDTH+1. A start in the DONE cycle restarts immediately, so
// the throughput is one operation per WIDTH+1 cycles.
// ---------------------------------------------------------------------------

module full_adder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum_out,
  output logic             cout,
  output logic [1:0]       fsm_state
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic b_bit;
  logic load_carry;
  logic fa_sum;
  logic fa_carry;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_q;

  // Subtraction is a + ~b + 1: invert B at the adder input and seed carry with 1.
  assign b_bit      = b_sr[0] ^ sub_q;
  assign load_carry = sub ? 1'b1 : cin;
`else
  assign b_bit      = b_sr[0];
  assign load_carry = cin;
`endif

  full_adder u_fa (
    .a  (a_sr[0]),
    .b  (b_bit),
    .c  (carry),
    .s  (fa_sum),
    .co (fa_carry)
  );

  assign fsm_state = state;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum_out <= '0;
      cout    <= 1'b0;
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      cnt     <= '0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state)
        // IDLE and DONE accept a start in the same way. DONE always leaves
        // after one cycle, which keeps done a single-cycle pulse.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_sr  <= a_in;
            b_sr  <= b_in;
            carry <= load_carry;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
            sub_q <= sub;
`endif
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end

        RUN: begin
          // The newest sum bit enters at the MSB. After WIDTH shifts, bit 0
          // of the operands has reached sum_out[0].
          sum_out <= {fa_sum, sum_out[WIDTH-1:1]};
          carry   <= fa_carry;
          a_sr    <= a_sr >> 1;
          b_sr    <= b_sr >> 1;
          if (cnt == LAST) begin
            cout  <= fa_carry;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// ---------------------------------------------------------------------------
// tb_serial_adder_ctrl -- directed bench for serial_adder_ctrl (WIDTH=8).
// Drivers push the hand-computed {cout,sum_out} into exp_q when they issue
// a start that should complete. A separate monitor pops and compares on
// every done pulse.
// ---------------------------------------------------------------------------
module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clock  = 1'b0;
  logic         resetn = 1'b1;
  logic         start  = 1'b0;
  logic         cin    = 1'b0;
  logic [W-1:0] a_in   = '0;
  logic [W-1:0] b_in   = '0;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub    = 1'b0;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum_out;
  logic         cout;
  logic [1:0]   fsm_state;

  int checks     = 0;
  int failures   = 0;
  int done_count = 0;
  int dc0;

  logic [W:0] exp_q[$];
  logic [W:0] mon_exp;

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .busy      (busy),
    .done      (done),
    .sum_out   (sum_out),
    .cout      (cout),
    .fsm_state (fsm_state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clock);
      if (resetn && done) begin
        done_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual={%0b,0x%0h} required=no_done", cout, sum_out);
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", {23'd0, cout, sum_out}, {23'd0, mon_exp});
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Issues one start and checks busy length and done latency. Operands are
  // scrambled during RUN to show that they are captured only at start.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W:0] exp, input string name);
    int busy_cycles;
    busy_cycles = 0;
    @(negedge clock);
    a_in = a; b_in = b; cin = c; start = 1'b1;
    exp_q.push_back(exp);
    @(negedge clock);                 // cycle 1
    start = 1'b0; a_in = ~a; b_in = ~b; cin = ~c;
    if (busy) busy_cycles++;
    repeat (W - 1) begin              // cycles 2..W
      @(negedge clock);
      if (busy) busy_cycles++;
    end
    @(negedge clock);                 // cycle W+1
    check({name, "_busy_cycles"}, busy_cycles, W);
    check({name, "_done_latency"}, {31'd0, done}, 32'd1);
    check({name, "_busy_at_done"}, {31'd0, busy}, 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    #1 resetn = 1'b0;
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_sum", {24'd0, sum_out}, 32'd0);
    check("reset_cout", {31'd0, cout}, 32'd0);
    check("reset_state", {30'd0, fsm_state}, 32'd0);
    repeat (2) @(negedge clock);
    resetn = 1'b1;

    do_op(8'h5A, 8'h3C, 1'b0, 9'h096, "add_5a_3c");
    do_op(8'hFF, 8'h01, 1'b0, 9'h100, "add_ff_01");
    do_op(8'hFF, 8'hFF, 1'b1, 9'h1FF, "add_ff_ff_c1");

    // Reset in the middle of RUN: outputs clear with no clock edge, and no done follows.
    @(negedge clock);
    a_in = 8'h77; b_in = 8'h11; cin = 1'b0; start = 1'b1;
    @(negedge clock);                 // cycle 1
    start = 1'b0;
    repeat (3) @(negedge clock);      // cycle 4
    check("abort_busy_before", {31'd0, busy}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_sum", {24'd0, sum_out}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    check("abort_state", {30'd0, fsm_state}, 32'd0);
    dc0 = done_count;
    @(negedge clock);
    resetn = 1'b1;
    repeat (12) @(negedge clock);
    check("abort_no_done", done_count - dc0, 0);
    do_op(8'h77, 8'h11, 1'b0, 9'h088, "after_abort");

    // A start while busy is ignored.
    dc0 = done_count;
    @(negedge clock);
    a_in = 8'h01; b_in = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h002);
    @(negedge clock);                 // cycle 1
    start = 1'b0;
    repeat (2) @(negedge clock);      // cycle 3
    a_in = 8'hF0; start = 1'b1;
    @(negedge clock);                 // cycle 4
    start = 1'b0; a_in = 8'h00;
    repeat (5) @(negedge clock);      // cycle 9
    check("ignore_done_latency", {31'd0, done}, 32'd1);
    repeat (12) @(negedge clock);
    check("ignore_one_done", done_count - dc0, 1);

    do_op(8'h80, 8'h80, 1'b0, 9'h100, "add_80_80");

    // start held high: three back-to-back operations, done every W+1 cycles.
    dc0 = done_count;
    @(negedge clock);
    a_in = 8'h10; b_in = 8'h20; cin = 1'b0; start = 1'b1;
    repeat (3) exp_q.push_back(9'h030);
    for (int k = 1; k <= 3 * (W + 1); k++) begin
      @(negedge clock);
      check("b2b_done_cycle", {31'd0, done}, (k % (W + 1) == 0) ? 32'd1 : 32'd0);
      if (k == 3 * (W + 1)) start = 1'b0;
    end
    repeat (12) @(negedge clock);
    check("b2b_done_count", done_count - dc0, 3);

`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b1;
    do_op(8'h10, 8'h01, 1'b1, 9'h10F, "sub_10_01");
    do_op(8'h01, 8'h02, 1'b0, 9'h0FF, "sub_01_02");
    sub = 1'b0;
    do_op(8'h10, 8'h01, 1'b1, 9'h012, "sub0_add");
`endif

    repeat (3) @(negedge clock);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
